// File: rtl/instr_encoder_loader.sv
// Program loader: encodes high-level RV32 instruction requests into 32-bit words
// and writes them sequentially into instruction memory, one word per two cycles.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        cls_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [11:0]       imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_e;

  typedef enum logic [2:0] {
    CLS_ADDI = 3'd0,
    CLS_R    = 3'd1,
    CLS_BEQ  = 3'd2,
    CLS_LW   = 3'd3,
    CLS_SW   = 3'd4,
    CLS_VEC  = 3'd5
  } cls_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_VEC    = 7'b1010111;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (cls_i)
      CLS_ADDI: enc_word = {imm_i, rs1_i, funct3_i, rd_i, OP_IMM};
      CLS_R:    enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_REG};
      CLS_VEC:  enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_VEC};
      CLS_LW:   enc_word = {imm_i, rs1_i, 3'b010, rd_i, OP_LOAD};
      CLS_SW:   enc_word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OP_STORE};
      // imm_i already holds offset[12:1]; B-type scatters those bits.
      CLS_BEQ:  enc_word = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, 3'b000,
                            imm_i[3:0], imm_i[10], OP_BRANCH};
      default:  enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (start_i) begin
      state_d = ST_LOAD;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (req_valid_i) begin
            if (enc_legal) begin
              wdata_d = enc_word;
              addr_d  = count_q[ADDR_W-1:0];
              state_d = ST_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end else if (finish_i) begin
            state_d = ST_DONE;
          end
        end
        ST_WRITE: begin
          count_d = count_q + ONE_C;
          state_d = (count_d == DEPTH_C || finish_i) ? ST_DONE : ST_LOAD;
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, matching what the hardware does.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // start_i cancels a pending write in the same cycle, so it must gate the strobe.
  assign imem_we_o    = (state_q == ST_WRITE) && !start_i;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign req_ready_o  = (state_q == ST_LOAD);
  assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed plan items plus randomized requests
// scored against an instruction-format reference model and a write queue.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;  // 0 drives the DEPTH=256 instance, 1 the DEPTH=4 one
  logic        start = 1'b0, finish = 1'b0, valid = 1'b0;
  logic [2:0]  cls = '0, f3 = '0;
  logic [6:0]  f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [11:0] imm = '0;

  logic        a_start, a_finish, a_valid, b_start, b_finish, b_valid;
  logic        a_ready, a_we, a_busy, a_done, a_err;
  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [8:0]  a_count, b_count;

  logic        ready, we, busy, done, err;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  count;

  assign a_start  = start  & ~sel;
  assign a_finish = finish & ~sel;
  assign a_valid  = valid  & ~sel;
  assign b_start  = start  & sel;
  assign b_finish = finish & sel;
  assign b_valid  = valid  & sel;

  assign ready = sel ? b_ready : a_ready;
  assign we    = sel ? b_we    : a_we;
  assign busy  = sel ? b_busy  : a_busy;
  assign done  = sel ? b_done  : a_done;
  assign err   = sel ? b_err   : a_err;
  assign addr  = sel ? b_addr  : a_addr;
  assign wdata = sel ? b_wdata : a_wdata;
  assign count = sel ? b_count : a_count;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .finish_i(a_finish),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .cls_i(cls), .funct3_i(f3),
    .funct7_i(f7), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .imem_we_o(a_we), .imem_addr_o(a_addr), .imem_wdata_o(a_wdata),
    .count_o(a_count), .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .finish_i(b_finish),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .cls_i(cls), .funct3_i(f3),
    .funct7_i(f7), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .imem_we_o(b_we), .imem_addr_o(b_addr), .imem_wdata_o(b_wdata),
    .count_o(b_count), .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   m_count = 0;
  bit   m_err   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder written from the instruction formats; beq works on the
  // real byte offset rather than on the pre-shifted immediate field.
  function automatic logic [31:0] ref_enc(input logic [2:0] c, input logic [2:0] fn3,
                                          input logic [6:0] fn7, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [11:0] im);
    logic [12:0] off;
    off = {im, 1'b0};
    case (c)
      3'd0:    return {im, s1, fn3, d, 7'h13};
      3'd1:    return {fn7, s2, s1, fn3, d, 7'h33};
      3'd2:    return {off[12], off[10:5], s2, s1, 3'b000, off[4:1], off[11], 7'h63};
      3'd3:    return {im, s1, 3'b010, d, 7'h03};
      3'd4:    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
      3'd5:    return {fn7, s2, s1, fn3, d, 7'h57};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_addr", 64'(addr), 64'(e.addr));
        check("strobe_data", 64'(wdata), 64'(e.data));
      end
    end
  end

  // Offers one request starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] c, input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [11:0] im);
    bit got;
    cls = c; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("accept_timeout", 64'(0), 64'(1));
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (c < 3'd6) begin
      exp_q.push_back('{m_count, ref_enc(c, fn3, fn7, d, s1, s2, im)});
      m_count++;
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);
    if (c < 3'd6) check("ready_in_write", 64'(ready), 64'(0));
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_count = 0;
    m_err = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(ready), 64'(0));
    check({tag, "_we"},    64'(we),    64'(0));
    check({tag, "_addr"},  64'(addr),  64'(0));
    check({tag, "_wdata"}, 64'(wdata), 64'(0));
    check({tag, "_count"}, 64'(count), 64'(0));
    check({tag, "_busy"},  64'(busy),  64'(0));
    check({tag, "_done"},  64'(done),  64'(0));
    check({tag, "_err"},   64'(err),   64'(0));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_a");
    sel = 1'b1;
    #1 check_zero("reset_b");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // First session: single addi.
    do_start();
    check("start_busy", 64'(busy), 64'(1));
    check("start_ready", 64'(ready), 64'(1));
    send(3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    idle(1);
    check("addi_data", 64'(wdata), 64'(32'h00500093));
    check("addi_count", 64'(count), 64'(m_count));

    // Back-to-back with valid held high.
    do_start();
    send(3'd1, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    send(3'd3, 3'd0, 7'd0, 5'd5, 5'd1, 5'd0, 12'd4);
    send(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 12'd8);
    idle(1);
    check("sw_data", 64'(wdata), 64'(32'h0020A423));
    check("b2b_count", 64'(count), 64'(3));
    send(3'd2, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 12'd4);
    idle(1);
    check("beq_data", 64'(wdata), 64'(32'h00208463));
    send(3'd5, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    idle(1);
    check("vec_data", 64'(wdata), 64'(32'h002081D7));

    // Illegal class: consumed, sticky error, no write.
    send(3'd6, 3'd1, 7'd9, 5'd7, 5'd7, 5'd7, 12'hABC);
    idle(1);
    check("illegal_err", 64'(err), 64'(1));
    check("illegal_count", 64'(count), 64'(m_count));
    send(3'd0, 3'd2, 7'd0, 5'd9, 5'd4, 5'd0, 12'h7FF);
    idle(1);
    check("after_illegal_addr", 64'(addr), 64'(m_count - 1));
    check("after_illegal_err", 64'(err), 64'(1));
    do_start();
    check("start_clears_err", 64'(err), 64'(0));
    check("start_clears_count", 64'(count), 64'(0));

    // Randomized requests, including illegal classes and idle gaps.
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom), 7'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 12'($urandom));
      idle($urandom_range(1, 3));
      check("rand_count", 64'(count), 64'(m_count));
      check("rand_err", 64'(err), 64'(m_err));
    end

    // start_i during the WRITE cycle drops the write.
    cls = 3'd0; f3 = 3'd0; rd = 5'd1; rs1 = 5'd1; imm = 12'd1;
    valid = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("start_write_we", 64'(we), 64'(0));
    @(posedge clk);
    #1 start = 1'b0;
    m_count = 0;
    m_err = 1'b0;
    @(negedge clk);
    check("start_write_count", 64'(count), 64'(0));
    check("start_write_addr", 64'(addr), 64'(0));
    check("start_write_ready", 64'(ready), 64'(1));

    // finish_i during WRITE completes the write, then DONE.
    send(3'd0, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 12'd3);
    finish = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    finish = 1'b0;
    check("finish_write_done", 64'(done), 64'(1));
    check("finish_write_busy", 64'(busy), 64'(0));
    check("finish_write_count", 64'(count), 64'(1));
    valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("done_ready", 64'(ready), 64'(0));
    end
    valid = 1'b0;

    // start and finish together: start wins; then finish alone.
    start = 1'b1;
    finish = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish = 1'b0;
    m_count = 0;
    check("start_wins_done", 64'(done), 64'(0));
    check("start_wins_ready", 64'(ready), 64'(1));
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("finish_load_done", 64'(done), 64'(1));

    // Reset mid-session.
    do_start();
    send(3'd0, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 12'd2);
    rst = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    @(negedge clk);

    // DEPTH=4 instance: four writes, then DONE and the fifth is never accepted.
    sel = 1'b1;
    #1;
    do_start();
    for (int i = 0; i < 4; i++)
      send(3'd0, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 12'(i + 10));
    idle(1);
    check("depth_done", 64'(done), 64'(1));
    check("depth_count", 64'(count), 64'(4));
    cls = 3'd1;
    valid = 1'b1;
    repeat (6) begin
      check("depth_fifth_ready", 64'(ready), 64'(0));
      @(negedge clk);
    end
    valid = 1'b0;
    sel = 1'b0;
    @(negedge clk);

    check("pending_writes", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
